// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the MEM stage and data_memory_sized.
// The master issues loads/stores; the slave answers with busy/done/data.
interface data_memory_sized_if;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        Mem_Write;
    logic        Mem_Read;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [63:0] Read_Data;
    logic        Mem_Busy;
    logic        Mem_Done;
    logic        Misaligned;

    modport master (
        output Mem_Addr, Write_Data, Mem_Write, Mem_Read, Size, Unsigned,
        input  Read_Data, Mem_Busy, Mem_Done, Misaligned
    );

    modport slave (
        input  Mem_Addr, Write_Data, Mem_Write, Mem_Read, Size, Unsigned,
        output Read_Data, Mem_Busy, Mem_Done, Misaligned
    );
endinterface

// File: rtl/data_memory_sized.sv
// Multi-cycle little-endian byte/half/word/dword data memory for the MEM stage.
// Define DMEM_RESET_CLEAR_EN to also zero the whole array on reset.
module data_memory_sized #(
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY     = 2,
    parameter int ADDR_BITS   = $clog2(DEPTH_BYTES)
) (
    input logic               clk,
    input logic               reset,
    data_memory_sized_if.slave bus
);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [63:0]            wdata_q, wdata_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic [63:0]            rdata_q, rdata_d;
    logic                   done_q, done_d;
    logic                   mis_q, mis_d;
    logic                   mem_we;

    logic [7:0]             mem_q [DEPTH_BYTES];

    logic [63:0]            raw;
    logic [63:0]            ext;
    logic [7:0]             bmask;
    logic                   misal;

    // Aligned accesses never straddle the top of the array, so the
    // natural ADDR_BITS wrap of addr_q + i is the modulo alias.
    always_comb begin
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            raw[8*i +: 8] = mem_q[addr_q + ADDR_BITS'(i)];
        end
    end

    always_comb begin
        misal = 1'b0;
        bmask = 8'h00;
        ext   = raw;
        unique case (size_q)
            2'd0: begin
                misal = 1'b0;
                bmask = 8'h01;
                ext   = uns_q ? {56'd0, raw[7:0]}
                              : {{56{raw[7]}}, raw[7:0]};
            end
            2'd1: begin
                misal = addr_q[0];
                bmask = 8'h03;
                ext   = uns_q ? {48'd0, raw[15:0]}
                              : {{48{raw[15]}}, raw[15:0]};
            end
            2'd2: begin
                misal = |addr_q[1:0];
                bmask = 8'h0F;
                ext   = uns_q ? {32'd0, raw[31:0]}
                              : {{32{raw[31]}}, raw[31:0]};
            end
            2'd3: begin
                misal = |addr_q[2:0];
                bmask = 8'hFF;
                ext   = raw;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.Mem_Read || bus.Mem_Write) begin
                    addr_d  = bus.Mem_Addr[ADDR_BITS-1:0];
                    wdata_d = bus.Write_Data;
                    size_d  = bus.Size;
                    uns_d   = bus.Unsigned;
                    rd_d    = bus.Mem_Read;
                    wr_d    = bus.Mem_Write;
                    state_d = BUSY;
                    cnt_d   = CNT_W'(1);
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(LATENCY)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (misal) begin
                        mis_d = 1'b1;
                    end else begin
                        if (rd_q) rdata_d = ext;
                        mem_we = wr_q && !reset;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
        end
    end

`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (bmask[i]) begin
                    mem_q[addr_q + ADDR_BITS'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (bmask[i]) begin
                    mem_q[addr_q + ADDR_BITS'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end
`endif

    assign bus.Read_Data  = rdata_q;
    assign bus.Mem_Busy   = (state_q == BUSY);
    assign bus.Mem_Done   = done_q;
    assign bus.Misaligned = mis_q;
endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: directed cases plus random traffic
// checked against a byte-array reference model.
module tb_data_memory_sized;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_sized_if dif();

    data_memory_sized #(
        .DEPTH_BYTES(DEPTH),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(dif)
    );

    typedef struct packed {
        logic [63:0] rdata;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem [DEPTH];
    logic [63:0] ref_rd;
    int          total = 0;
    int          bad = 0;

    function automatic logic [63:0] model_load(int a, int sz, bit uns);
        int n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = v | (64'(ref_mem[(a + i) % DEPTH]) << (8 * i));
        end
        if (!uns && n < 8 && v[8*n-1]) begin
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        end
        return v;
    endfunction

    task automatic clear_inputs();
        dif.Mem_Read   = 1'b0;
        dif.Mem_Write  = 1'b0;
        dif.Mem_Addr   = '0;
        dif.Write_Data = '0;
        dif.Size       = 2'd0;
        dif.Unsigned   = 1'b0;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge
    // where Mem_Done is seen, so the next call issues back-to-back.
    task automatic issue(bit rd, bit wr, int a, logic [63:0] d,
                         int sz, bit uns, bit spam);
        exp_t e;
        int   n;
        int   bcnt;
        bit   got;
        bit   mis;
        n   = 1 << sz;
        mis = (a % n) != 0;
        if (!mis && rd) ref_rd = model_load(a, sz, uns);
        if (!mis && wr) begin
            for (int i = 0; i < n; i++) begin
                ref_mem[(a + i) % DEPTH] = d[8*i +: 8];
            end
        end
        e.rdata = ref_rd;
        e.mis   = mis;
        exp_q.push_back(e);
        dif.Mem_Read   = rd;
        dif.Mem_Write  = wr;
        dif.Mem_Addr   = 64'(a);
        dif.Write_Data = d;
        dif.Size       = 2'(sz);
        dif.Unsigned   = uns;
        bcnt = 0;
        got  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dif.Mem_Done) begin
                got = 1;
                break;
            end
            if (dif.Mem_Busy) bcnt++;
            if (spam && k == 0) begin
                dif.Mem_Read   = 1'b1;
                dif.Mem_Write  = 1'b1;
                dif.Mem_Addr   = 64'((a + 40) % DEPTH);
                dif.Write_Data = {$urandom, $urandom};
                dif.Size       = 2'd3;
            end else begin
                clear_inputs();
            end
        end
        total++;
        if (!got || bcnt != LAT) begin
            bad++;
            $display("FAIL busy_len: got=%0d busy=%0d want done with busy=%0d",
                     got, bcnt, LAT);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dif.Mem_Done) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: rdata=%h mis=%b",
                             dif.Read_Data, dif.Misaligned);
                end else begin
                    e = exp_q.pop_front();
                    if (dif.Read_Data !== e.rdata || dif.Misaligned !== e.mis) begin
                        bad++;
                        $display("FAIL done_resp: rdata=%h mis=%b want %h mis=%b",
                                 dif.Read_Data, dif.Misaligned, e.rdata, e.mis);
                    end
                end
            end else if (dif.Misaligned) begin
                total++;
                bad++;
                $display("FAIL mis_without_done: got 1 want 0");
            end
        end
    end

    initial begin
        int a;
        int sz;
        bit rd;
        bit wr;
        reset = 1'b1;
        clear_inputs();
        ref_rd = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_rdata", dif.Read_Data, 64'd0);
        check("rst_busy", 64'(dif.Mem_Busy), 64'd0);
        check("rst_done", 64'(dif.Mem_Done), 64'd0);
        check("rst_mis", 64'(dif.Misaligned), 64'd0);

        for (int i = 0; i < DEPTH; i += 8) begin
            issue(0, 1, i, {$urandom, $urandom}, 3, 0, 0);
        end

        issue(0, 1, 0, 64'h1122334455667788, 3, 0, 0);
        issue(1, 0, 0, 64'd0, 3, 0, 0);
        issue(1, 0, 3, 64'd0, 0, 0, 0);
        issue(0, 1, 8, 64'h80, 0, 0, 0);
        issue(1, 0, 8, 64'd0, 0, 0, 0);
        issue(1, 0, 8, 64'd0, 0, 1, 0);
        issue(0, 1, 2, 64'hBEEF, 1, 0, 0);
        issue(1, 0, 0, 64'd0, 3, 0, 0);
        issue(1, 0, 3, 64'd0, 1, 0, 0);
        issue(0, 1, 3, 64'hDEAD, 1, 0, 0);
        issue(1, 0, 0, 64'd0, 3, 1, 0);

        issue(1, 0, 0, 64'd0, 3, 0, 1);
        issue(1, 0, 40, 64'd0, 3, 0, 0);

        issue(0, 1, 16, 64'hA, 3, 0, 0);
        issue(1, 1, 16, 64'h4, 3, 0, 0);
        issue(1, 0, 16, 64'd0, 3, 0, 0);
        issue(0, 1, DEPTH + 16, 64'h77, 3, 0, 0);
        issue(1, 0, 16, 64'd0, 3, 0, 0);
        issue(1, 0, DEPTH - 8, 64'd0, 3, 0, 0);

        dif.Mem_Write  = 1'b1;
        dif.Mem_Addr   = 64'd24;
        dif.Write_Data = 64'h5;
        dif.Size       = 2'd3;
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_rd = '0;
`ifdef DMEM_RESET_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
`endif
        check("midrst_busy", 64'(dif.Mem_Busy), 64'd0);
        check("midrst_rdata", dif.Read_Data, 64'd0);
        repeat (4) @(negedge clk);
        issue(1, 0, 24, 64'd0, 3, 0, 0);
        issue(1, 0, 0, 64'd0, 3, 0, 0);

        for (int t = 0; t < 300; t++) begin
            sz = $urandom_range(0, 3);
            a  = $urandom_range(0, 2 * DEPTH - 1);
            if ($urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
            rd = $urandom_range(0, 1);
            wr = rd ? bit'($urandom_range(0, 1)) : 1'b1;
            issue(rd, wr, a, {$urandom, $urandom}, sz,
                  bit'($urandom_range(0, 1)), t % 17 == 0);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
